wb_mem_slave: RTL and testbench
===============================

WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning idle cycles inserted between request sampling and ack (0..7).
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of memory depth in `DataWidth` words.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port wb_cyc  input  1  bus cycle active, driven by the arbiter.
REQ-006 SHALL have port wb_stb  input  1  strobe, driven by the arbiter.
REQ-007 SHALL have port wb_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port wb_adr  input  `DataWidth`  word address.
REQ-009 SHALL have port wb_dat_i  input  `DataWidth`  write data.
REQ-010 SHALL have port wb_dat_o  output  `DataWidth`  read data.
REQ-011 SHALL have port wb_ack  output  1  transfer complete, single-cycle pulse.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, ACK; reset state IDLE.
REQ-013 IDLE: on wb_cyc&wb_stb sampled high SHALL latch adr/we/dat_i, load wait counter with WAIT_STATES, go WAIT (or ACK if WAIT_STATES=0).
REQ-014 WAIT: SHALL decrement counter each cycle; at counter 1 go ACK.
REQ-015 WAIT: if wb_cyc or wb_stb drops, SHALL abort to IDLE, no write, no ack.
REQ-016 ACK: wb_ack SHALL be high exactly one cycle; next state always IDLE.
REQ-017 Latency: wb_ack SHALL assert WAIT_STATES+1 cycles after the edge sampling the request.
REQ-018 A request still asserted in the cycle after ACK SHALL be treated as new (arbiter drops stb after ack).
REQ-019 Write SHALL commit to memory on the edge entering ACK; commit exactly once per transfer.
REQ-020 Read: wb_dat_o SHALL carry mem[latched adr] while wb_ack=1, and 0 otherwise.
REQ-021 Address in range iff upper `DataWidth`-DEPTH_LOG2 bits are zero; out-of-range write SHALL be dropped, read SHALL return 0, ack still given.
REQ-022 Read-after-write to same address in back-to-back transfers SHALL return the new data.
REQ-023 wb_we/wb_adr/wb_dat_i changes after sampling SHALL NOT affect the transfer in progress.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, wb_ack=0, wb_dat_o=0, counter=0, latches=0.
REQ-025 Reset mid-transfer SHALL drop the transfer; pending write SHALL NOT commit; memory contents unspecified/retained.
REQ-026 First request SHALL be accepted on the first edge with rst_n high.

Configuration
REQ-027 Macro WB_MEM_ERR_EN defined: SHALL add output wb_err (1 bit); out-of-range access gets wb_err pulse in ACK cycle instead of wb_ack, same timing.
REQ-028 WB_MEM_ERR_EN undefined: no wb_err port; out-of-range behaviour per REQ-021.

Structure
REQ-029 `DataWidth`, `DataWordLength`, state encodings SHALL live in shared define.v.
REQ-030 Memory array SHALL be sub-module sp_ram (single-port, sync write, registered read, DEPTH_LOG2 param).

Verification
REQ-031 WAIT_STATES=1: write 0x1234 to adr 0x0005, then read 0x0005 -> ack 2 cycles after each request, read data 0x1234.
REQ-032 WAIT_STATES=0: back-to-back writes 0x0001..0x0004 to adr 0..3, reads -> each ack 1 cycle after request, data matches.
REQ-033 Drop wb_stb in WAIT during write 0xBEEF to adr 0x10 -> no ack; later read of 0x10 returns prior value.
REQ-034 Read adr 0x8000 (DEPTH_LOG2=10) -> ack, data 0x0000; with WB_MEM_ERR_EN, wb_err=1, wb_ack=0.
REQ-035 Assert rst_n low in WAIT of write 0xAAAA -> wb_ack=0 immediately; after release, read of that adr is not 0xAAAA.
REQ-036 Change wb_adr/wb_dat_i during WAIT -> write lands at originally sampled address with original data.

Source files
------------

// File: rtl/wb_mem_slave_pkg.sv
// Shared word-width constants, FSM state encodings and the address range helper
// used by the Wishbone memory slave and its RAM.
package wb_mem_slave_pkg;

    localparam int DataWidth      = 16;
    localparam int DataWordLength = DataWidth / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // An address is backed by RAM only when every bit above the RAM index is zero.
    function automatic logic addr_in_range(input logic [DataWidth-1:0] adr, input int depth_log2);
        return ((adr >> depth_log2) == '0);
    endfunction

endpackage

// File: rtl/wb_mem_slave_sp_ram.sv
// Single-port RAM with synchronous write and registered (read-first) read.
module sp_ram
    import wb_mem_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DataWidth-1:0]  wdata,
    output logic [DataWidth-1:0]  rdata
);

    logic [DataWidth-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic memory slave with WAIT_STATES idle cycles before ack.
// Optional feature: define WB_MEM_ERR_EN to add wb_err for out-of-range accesses.
//
// state | meaning
// IDLE  | waiting for wb_cyc & wb_stb; request latched on the sampling edge
// WAIT  | counting down wait states; bus drop aborts the transfer
// ACK   | single-cycle ack (or err) pulse; always returns to IDLE
module wb_mem_slave
    import wb_mem_slave_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_cyc,
    input  logic                 wb_stb,
    input  logic                 wb_we,
    input  logic [DataWidth-1:0] wb_adr,
    input  logic [DataWidth-1:0] wb_dat_i,
    output logic [DataWidth-1:0] wb_dat_o,
    output logic                 wb_ack
`ifdef WB_MEM_ERR_EN
    ,
    output logic                 wb_err
`endif
);

    localparam logic [2:0] WaitLoad = 3'(WAIT_STATES);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [2:0]           cnt;
    logic                 we_q;
    logic [DataWidth-1:0] adr_q;
    logic [DataWidth-1:0] dat_q;

    logic                 req;
    logic                 enter_ack;
    logic                 use_bus;
    logic [DataWidth-1:0] ram_adr;
    logic [DataWidth-1:0] ram_wdata;
    logic                 ram_we_sel;
    logic                 ram_wr;
    logic [DataWidth-1:0] ram_rdata;
    logic                 ack_state;
    logic                 range_q;

    assign req = wb_cyc & wb_stb;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == 3'd1) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req) begin
                cnt   <= WaitLoad;
                we_q  <= wb_we;
                adr_q <= wb_adr;
                dat_q <= wb_dat_i;
            end else if (state == ST_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // In IDLE the RAM sees the live bus so a zero-wait transfer can commit or
    // read on its sampling edge; afterwards it sees only the latched request.
    assign use_bus    = (state == ST_IDLE);
    assign ram_adr    = use_bus ? wb_adr   : adr_q;
    assign ram_wdata  = use_bus ? wb_dat_i : dat_q;
    assign ram_we_sel = use_bus ? wb_we    : we_q;
    assign enter_ack  = (state_nxt == ST_ACK) && (state != ST_ACK);
    assign ram_wr     = rst_n & enter_ack & ram_we_sel & addr_in_range(ram_adr, DEPTH_LOG2);

    sp_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_wr),
        .addr  (ram_adr[DEPTH_LOG2-1:0]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign ack_state = (state == ST_ACK);
    assign range_q   = addr_in_range(adr_q, DEPTH_LOG2);
    assign wb_dat_o  = (ack_state && !we_q && range_q) ? ram_rdata : '0;

`ifdef WB_MEM_ERR_EN
    assign wb_ack = ack_state & range_q;
    assign wb_err = ack_state & ~range_q;
`else
    assign wb_ack = ack_state;
`endif

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave: one instance with one wait state, one with none.
module tb_wb_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb0 = 1'b0;
    logic        stb1 = 1'b0;
    logic        we_s = 1'b0;
    logic [15:0] adr_s = 16'h0;
    logic [15:0] dat_s = 16'h0;
    logic [15:0] dat0, dat1;
    logic        ack0, ack1;
    logic        err0, err1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_mem_slave #(.WAIT_STATES(1), .DEPTH_LOG2(10)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb0), .wb_we(we_s),
        .wb_adr(adr_s), .wb_dat_i(dat_s), .wb_dat_o(dat0), .wb_ack(ack0)
`ifdef WB_MEM_ERR_EN
        , .wb_err(err0)
`endif
    );

    wb_mem_slave #(.WAIT_STATES(0), .DEPTH_LOG2(10)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb1), .wb_we(we_s),
        .wb_adr(adr_s), .wb_dat_i(dat_s), .wb_dat_o(dat1), .wb_ack(ack1)
`ifdef WB_MEM_ERR_EN
        , .wb_err(err1)
`endif
    );

`ifndef WB_MEM_ERR_EN
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_done(input int sel);
        return (sel == 0) ? (ack0 | err0) : (ack1 | err1);
    endfunction

    // One bus transfer; lat counts rising edges from presenting the request
    // until ack/err is seen (99 = never). Perturb scrambles we/adr/dat after sampling.
    task automatic xfer(input int sel, input logic we, input logic [15:0] adr,
                        input logic [15:0] dat, input bit perturb,
                        output logic [15:0] rd, output int lat,
                        output logic err, output logic done_after);
        @(negedge clk);
        cyc = 1'b1; we_s = we; adr_s = adr; dat_s = dat;
        if (sel == 0) stb0 = 1'b1; else stb1 = 1'b1;
        lat = 99; rd = 16'h0; err = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (perturb) begin
                we_s = ~we; adr_s = ~adr; dat_s = ~dat;
            end
            if (cur_done(sel)) begin
                lat = i;
                rd  = (sel == 0) ? dat0 : dat1;
                err = (sel == 0) ? err0 : err1;
                break;
            end
        end
        cyc = 1'b0; stb0 = 1'b0; stb1 = 1'b0;
        @(posedge clk); #1;
        done_after = cur_done(sel);
    endtask

    initial begin
        logic [15:0] rd;
        int          lat;
        logic        err;
        logic        after;
        logic        seen;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack_w1", {31'd0, ack0}, 32'd0);
        check("reset_dat_w1", {16'd0, dat0}, 32'd0);
        check("reset_ack_w0", {31'd0, ack1}, 32'd0);
        check("reset_dat_w0", {16'd0, dat1}, 32'd0);
        rst_n = 1'b1;

        // Write then read with one wait state
        xfer(0, 1'b1, 16'h0005, 16'h1234, 1'b0, rd, lat, err, after);
        check("w1_wr_lat", lat, 2);
        check("w1_wr_pulse", {31'd0, after}, 32'd0);
        xfer(0, 1'b0, 16'h0005, 16'h0000, 1'b0, rd, lat, err, after);
        check("w1_rd_lat", lat, 2);
        check("w1_rd_data", {16'd0, rd}, 32'h1234);
        check("w1_rd_pulse", {31'd0, after}, 32'd0);
        check("w1_dat_idle", {16'd0, dat0}, 32'd0);

        // Out-of-range accesses
        xfer(0, 1'b0, 16'h8000, 16'h0000, 1'b0, rd, lat, err, after);
        check("oor_rd_lat", lat, 2);
        check("oor_rd_data", {16'd0, rd}, 32'h0);
`ifdef WB_MEM_ERR_EN
        check("oor_rd_err", {31'd0, err}, 32'd1);
`else
        check("oor_rd_err", {31'd0, err}, 32'd0);
`endif
        xfer(0, 1'b1, 16'h8005, 16'hDEAD, 1'b0, rd, lat, err, after);
        check("oor_wr_lat", lat, 2);
        xfer(0, 1'b0, 16'h0005, 16'h0000, 1'b0, rd, lat, err, after);
        check("oor_wr_dropped", {16'd0, rd}, 32'h1234);

        // Abort in WAIT by dropping stb
        xfer(0, 1'b1, 16'h0010, 16'h5555, 1'b0, rd, lat, err, after);
        @(negedge clk);
        cyc = 1'b1; stb0 = 1'b1; we_s = 1'b1; adr_s = 16'h0010; dat_s = 16'hBEEF;
        @(posedge clk); #1;
        stb0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | ack0 | err0;
        end
        cyc = 1'b0;
        check("abort_no_ack", {31'd0, seen}, 32'd0);
        xfer(0, 1'b0, 16'h0010, 16'h0000, 1'b0, rd, lat, err, after);
        check("abort_no_write", {16'd0, rd}, 32'h5555);

        // Reset during WAIT of a write
        xfer(0, 1'b1, 16'h0020, 16'h7777, 1'b0, rd, lat, err, after);
        @(negedge clk);
        cyc = 1'b1; stb0 = 1'b1; we_s = 1'b1; adr_s = 16'h0020; dat_s = 16'hAAAA;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_ack_low", {31'd0, ack0}, 32'd0);
        check("rst_dat_low", {16'd0, dat0}, 32'd0);
        @(posedge clk); #1;
        check("rst_hold_ack", {31'd0, ack0}, 32'd0);
        @(negedge clk);
        cyc = 1'b0; stb0 = 1'b0; rst_n = 1'b1;
        xfer(0, 1'b0, 16'h0020, 16'h0000, 1'b0, rd, lat, err, after);
        check("rst_no_commit", {16'd0, rd}, 32'h7777);

        // Bus changes after sampling must not affect the transfer
        xfer(0, 1'b1, 16'h0031, 16'h3333, 1'b0, rd, lat, err, after);
        xfer(0, 1'b1, 16'h0030, 16'h1111, 1'b1, rd, lat, err, after);
        check("perturb_lat", lat, 2);
        xfer(0, 1'b0, 16'h0030, 16'h0000, 1'b0, rd, lat, err, after);
        check("perturb_orig", {16'd0, rd}, 32'h1111);
        xfer(0, 1'b0, 16'h0031, 16'h0000, 1'b0, rd, lat, err, after);
        check("perturb_other", {16'd0, rd}, 32'h3333);

        // Zero wait states: back-to-back writes then reads
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1'b1, 16'(i), 16'(i + 1), 1'b0, rd, lat, err, after);
            check($sformatf("w0_wr_lat_%0d", i), lat, 1);
        end
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1'b0, 16'(i), 16'h0000, 1'b0, rd, lat, err, after);
            check($sformatf("w0_rd_lat_%0d", i), lat, 1);
            check($sformatf("w0_rd_data_%0d", i), {16'd0, rd}, 32'(i + 1));
        end
        xfer(1, 1'b1, 16'h0002, 16'hCAFE, 1'b0, rd, lat, err, after);
        xfer(1, 1'b0, 16'h0002, 16'h0000, 1'b0, rd, lat, err, after);
        check("w0_raw", {16'd0, rd}, 32'hCAFE);
        check("w0_pulse", {31'd0, after}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
